// File: rtl/dm_port_arbiter_if.sv
// Bus bundle for the data-memory port arbiter: the CPU load/store port,
// the debug/loader port, the shared DataMemory port and the busy flag.
// The arbiter uses the slave modport; requesters and memory use master.
interface dm_port_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    // CPU load/store port
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    // Debug/loader port
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    // Shared memory port
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;

    logic              busy;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  dm_we, dm_addr, dm_wdata,
        output dm_rdata,
        input  busy
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output dm_we, dm_addr, dm_wdata,
        input  dm_rdata,
        output busy
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter in front of the single DataMemory port. The CPU has
// fixed priority; an aging counter lets the debug port win after MAX_WAIT
// lost arbitrations. Each access runs IDLE -> ACCESS -> RESP, with a
// one-cycle acknowledge to the owning port in RESP.
module dm_port_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int MAX_WAIT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    dm_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    localparam logic       OWN_CPU    = 1'b0;
    localparam logic       OWN_DBG    = 1'b1;

    state_t            state_r;
    logic              owner_r;
    logic [3:0]        wait_cnt_r;
    logic              cpu_ack_r;
    logic              dbg_ack_r;
    logic [DATA_W-1:0] cpu_rdata_r;
    logic [DATA_W-1:0] dbg_rdata_r;
    logic              dm_we_r;
    logic [ADDR_W-1:0] dm_addr_r;
    logic [DATA_W-1:0] dm_wdata_r;
    logic              busy_r;

    logic              dbg_wins_s;
    logic [3:0]        wait_inc_s;

    // Winner selection and the saturating aged wait count for the next decision
    always_comb begin
        dbg_wins_s = 1'b0;
        wait_inc_s = wait_cnt_r;
        if (bus.dbg_req && (!bus.cpu_req || (wait_cnt_r == MAX_WAIT_C))) begin
            dbg_wins_s = 1'b1;
        end else begin
            dbg_wins_s = 1'b0;
        end
        if (wait_cnt_r >= MAX_WAIT_C) begin
            wait_inc_s = MAX_WAIT_C;
        end else begin
            wait_inc_s = wait_cnt_r + 4'd1;
        end
    end

    // Access sequencer: decide in IDLE, drive memory in ACCESS, acknowledge in RESP
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= IDLE;
            owner_r     <= OWN_CPU;
            wait_cnt_r  <= 4'd0;
            cpu_ack_r   <= 1'b0;
            dbg_ack_r   <= 1'b0;
            cpu_rdata_r <= {DATA_W{1'b0}};
            dbg_rdata_r <= {DATA_W{1'b0}};
            dm_we_r     <= 1'b0;
            dm_addr_r   <= {ADDR_W{1'b0}};
            dm_wdata_r  <= {DATA_W{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cpu_ack_r <= 1'b0;
                    dbg_ack_r <= 1'b0;
                    if (dbg_wins_s) begin
                        owner_r    <= OWN_DBG;
                        dm_we_r    <= bus.dbg_we;
                        dm_addr_r  <= bus.dbg_addr;
                        dm_wdata_r <= bus.dbg_wdata;
                        wait_cnt_r <= 4'd0;
                        busy_r     <= 1'b1;
                        state_r    <= ACCESS;
                    end else if (bus.cpu_req) begin
                        owner_r    <= OWN_CPU;
                        dm_we_r    <= bus.cpu_we;
                        dm_addr_r  <= bus.cpu_addr;
                        dm_wdata_r <= bus.cpu_wdata;
                        // Debug lost this round only if it was actually asking
                        wait_cnt_r <= bus.dbg_req ? wait_inc_s : 4'd0;
                        busy_r     <= 1'b1;
                        state_r    <= ACCESS;
                    end else begin
                        // No request at all, so dbg_req is low here
                        wait_cnt_r <= 4'd0;
                        state_r    <= IDLE;
                    end
                end
                ACCESS: begin
                    // The write (if any) commits on this edge; reads capture dm_rdata
                    dm_we_r <= 1'b0;
                    if (owner_r == OWN_DBG) begin
                        dbg_ack_r <= 1'b1;
                        cpu_ack_r <= 1'b0;
                        if (!dm_we_r) begin
                            dbg_rdata_r <= bus.dm_rdata;
                        end else begin
                            dbg_rdata_r <= dbg_rdata_r;
                        end
                    end else begin
                        cpu_ack_r <= 1'b1;
                        dbg_ack_r <= 1'b0;
                        if (!dm_we_r) begin
                            cpu_rdata_r <= bus.dm_rdata;
                        end else begin
                            cpu_rdata_r <= cpu_rdata_r;
                        end
                    end
                    state_r <= RESP;
                end
                RESP: begin
                    cpu_ack_r <= 1'b0;
                    dbg_ack_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    cpu_ack_r <= 1'b0;
                    dbg_ack_r <= 1'b0;
                    dm_we_r   <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_ack   = cpu_ack_r;
    assign bus.cpu_rdata = cpu_rdata_r;
    assign bus.dbg_ack   = dbg_ack_r;
    assign bus.dbg_rdata = dbg_rdata_r;
    assign bus.dm_we     = dm_we_r;
    assign bus.dm_addr   = dm_addr_r;
    assign bus.dm_wdata  = dm_wdata_r;
    assign bus.busy      = busy_r;

endmodule
